// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared constants for the bit-serial adder.
//   DEFAULT_WIDTH : default operand/sum width
//   IDLE/RUN/DONE : FSM state encodings (state_t)
package serial_adder_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t RUN  = 2'd1;
   localparam state_t DONE = 2'd2;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// fa_cell: one-bit full adder built from two half-adder stages and an OR.
//   a, b, cin : input bits
//   sum       : a ^ b ^ cin
//   carry     : carry-out
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic carry
);

   logic hs1;
   logic hc1;
   logic hc2;

   // First half adder on the operand bits
   assign hs1   = a ^ b;
   assign hc1   = a & b;
   // Second half adder folds in the carry
   assign sum   = hs1 ^ cin;
   assign hc2   = hs1 & cin;
   assign carry = hc1 | hc2;

endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder, one bit per clock through a
// single fa_cell. Takes WIDTH RUN cycles; done pulses for one cycle.
//   clk, rst        : clock, synchronous active-high reset
//   start, a, b, cin: request and operands (accepted when busy is low)
//   busy            : addition in progress
//   done            : one-cycle result-valid pulse
//   sum, cout       : result, held until the next accepted start
//   ovf             : two's-complement overflow (only with SERIAL_ADDER_OVF_EN)
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned     CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             fa_sum;
   logic             fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   fa_cell u_fa (
      .a     (a_q[0]),
      .b     (b_q[0]),
      .cin   (carry_q),
      .sum   (fa_sum),
      .carry (fa_carry)
   );

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            carry_d = fa_carry;
            sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            if (cnt_q == LAST) begin
               // Counter parks at LAST rather than wrapping
               state_d = DONE;
               done_d  = 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
               // carry_q here is the carry into the MSB
               ovf_d   = carry_q ^ fa_carry;
`endif
            end else begin
               cnt_d  = cnt_q + CNT_W'(1);
               busy_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder (WIDTH=8).
// Define SERIAL_ADDER_OVF_EN to also exercise the ovf port.
module tb_serial_adder;

   localparam int unsigned W       = 8;
   localparam int          TIMEOUT = 40;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic         ovf;
   logic         ovf_q[$];
`endif

   logic [W:0] exp_q[$];
   int tests = 0;
   int fails = 0;

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   always #5 clk = ~clk;

   // Drive a start for one cycle from the current negedge; record expectation
   task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
      logic [W:0] full;
      a = ta; b = tb; cin = tc; start = 1'b1;
      full = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
      exp_q.push_back(full);
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q.push_back((ta[W-1] == tb[W-1]) && (full[W-1] != ta[W-1]));
`endif
      @(negedge clk);
      start = 1'b0;
   endtask

   // Count negedges (from the one after issue) until done; bounded
   task automatic wait_done(input int lat0, output int lat, output int bcnt);
      lat = lat0; bcnt = 0;
      while (done !== 1'b1 && lat < TIMEOUT) begin
         if (busy === 1'b1) bcnt++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        output int lat, output int bcnt);
      @(negedge clk);
      issue(ta, tb, tc);
      wait_done(1, lat, bcnt);
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      repeat (2) @(negedge clk);
      tests++;
      if ({busy, done, cout, sum} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: busy=%b done=%b cout=%b sum=%h, want all 0", busy, done, cout, sum);
      end
`ifdef SERIAL_ADDER_OVF_EN
      tests++;
      if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
      rst = 1'b0;
   endtask

   task automatic test_basic;
      int lat, bcnt;
      logic [W:0] e;
      do_op(8'hFF, 8'h01, 1'b0, lat, bcnt);
      tests++;
      if (lat !== W + 1) begin fails++; $display("FAIL basic_latency: got %0d want %0d", lat, W + 1); end
      tests++;
      if (bcnt !== W) begin fails++; $display("FAIL basic_busy_cycles: got %0d want %0d", bcnt, W); end
      e = exp_q.pop_front();
`ifdef SERIAL_ADDER_OVF_EN
      void'(ovf_q.pop_front());
`endif
      tests++;
      if ({cout, sum} !== e) begin fails++; $display("FAIL basic_result: got %h want %h", {cout, sum}, e); end
      @(negedge clk);
      tests++;
      if (done !== 1'b0) begin fails++; $display("FAIL basic_done_pulse: done=%b after one cycle, want 0", done); end
      tests++;
      if ({cout, sum} !== 9'h100) begin fails++; $display("FAIL basic_hold: got %h want 100", {cout, sum}); end
   endtask

   task automatic test_back_to_back;
      int lat, bcnt;
      logic [W:0] e;
      do_op(8'h3C, 8'h5A, 1'b1, lat, bcnt);
      e = exp_q.pop_front();
`ifdef SERIAL_ADDER_OVF_EN
      void'(ovf_q.pop_front());
`endif
      tests++;
      if ({cout, sum} !== 9'h097 || e !== 9'h097) begin
         fails++; $display("FAIL b2b_first: got %h want 097", {cout, sum});
      end
      // Still in the DONE cycle: start here must be taken immediately
      issue(8'h01, 8'h01, 1'b0);
      tests++;
      if (busy !== 1'b1) begin fails++; $display("FAIL b2b_no_idle: busy=%b want 1", busy); end
      wait_done(1, lat, bcnt);
      tests++;
      if (lat !== W + 1) begin fails++; $display("FAIL b2b_latency: got %0d want %0d", lat, W + 1); end
      e = exp_q.pop_front();
`ifdef SERIAL_ADDER_OVF_EN
      void'(ovf_q.pop_front());
`endif
      tests++;
      if ({cout, sum} !== e) begin fails++; $display("FAIL b2b_second: got %h want %h", {cout, sum}, e); end
   endtask

   task automatic test_ignore_start;
      int lat, bcnt;
      logic [W:0] e;
      @(negedge clk);
      issue(8'h12, 8'h34, 1'b0);
      repeat (2) @(negedge clk);
      a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
      wait_done(4, lat, bcnt);
      tests++;
      if (lat !== W + 1) begin fails++; $display("FAIL ignore_latency: got %0d want %0d", lat, W + 1); end
      e = exp_q.pop_front();
`ifdef SERIAL_ADDER_OVF_EN
      void'(ovf_q.pop_front());
`endif
      tests++;
      if ({cout, sum} !== e) begin fails++; $display("FAIL ignore_result: got %h want %h", {cout, sum}, e); end
      @(negedge clk);
      tests++;
      if (busy !== 1'b0) begin fails++; $display("FAIL ignore_no_restart: busy=%b want 0", busy); end
   endtask

   task automatic test_reset_abort;
      int seen;
      @(negedge clk);
      issue(8'h55, 8'h66, 1'b1);
      void'(exp_q.pop_back());
`ifdef SERIAL_ADDER_OVF_EN
      void'(ovf_q.pop_back());
`endif
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tests++;
      if ({busy, done, cout, sum} !== '0) begin
         fails++;
         $display("FAIL abort_outputs: busy=%b done=%b cout=%b sum=%h, want all 0", busy, done, cout, sum);
      end
`ifdef SERIAL_ADDER_OVF_EN
      tests++;
      if (ovf !== 1'b0) begin fails++; $display("FAIL abort_ovf: got %b want 0", ovf); end
`endif
      seen = 0;
      repeat (2 * W) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) seen++;
      end
      tests++;
      if (seen !== 0) begin fails++; $display("FAIL abort_no_done: %0d active cycles, want 0", seen); end
   endtask

`ifdef SERIAL_ADDER_OVF_EN
   task automatic test_ovf;
      int lat, bcnt;
      logic [W:0] e;
      logic eo;
      do_op(8'h7F, 8'h01, 1'b0, lat, bcnt);
      e = exp_q.pop_front(); eo = ovf_q.pop_front();
      tests++;
      if (ovf !== 1'b1 || eo !== 1'b1 || sum !== 8'h80 || e !== {cout, sum}) begin
         fails++; $display("FAIL ovf_pos: ovf=%b sum=%h want ovf=1 sum=80", ovf, sum);
      end
      do_op(8'hFF, 8'h01, 1'b0, lat, bcnt);
      e = exp_q.pop_front(); eo = ovf_q.pop_front();
      tests++;
      if (ovf !== 1'b0 || eo !== 1'b0 || cout !== 1'b1 || e !== {cout, sum}) begin
         fails++; $display("FAIL ovf_neg: ovf=%b cout=%b want ovf=0 cout=1", ovf, cout);
      end
   endtask
`endif

   task automatic test_random;
      int lat, bcnt;
      logic [W:0] e;
      for (int i = 0; i < 1000; i++) begin
         do_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)), lat, bcnt);
         e = exp_q.pop_front();
         tests++;
         if (lat !== W + 1 || {cout, sum} !== e) begin
            fails++;
            $display("FAIL random_%0d: got %h lat %0d want %h lat %0d", i, {cout, sum}, lat, e, W + 1);
         end
`ifdef SERIAL_ADDER_OVF_EN
         begin
            logic eo;
            eo = ovf_q.pop_front();
            tests++;
            if (ovf !== eo) begin fails++; $display("FAIL random_ovf_%0d: got %b want %b", i, ovf, eo); end
         end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_ignore_start();
      test_reset_abort();
`ifdef SERIAL_ADDER_OVF_EN
      test_ovf();
`endif
      test_random();
      tests++;
      if (exp_q.size() != 0) begin fails++; $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size()); end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand and sum width in bits (legal range 2..32).
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 Port rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-004 Port start  input  1  SHALL request a new addition; it is sampled only when busy is low.
REQ-005 Port a  input  WIDTH  SHALL be operand A, captured when start is accepted.
REQ-006 Port b  input  WIDTH  SHALL be operand B, captured when start is accepted.
REQ-007 Port cin  input  1  SHALL be the carry-in, captured when start is accepted.
REQ-008 Port busy  output  1  SHALL be high while an addition is in progress.
REQ-009 Port done  output  1  SHALL be a one-cycle pulse marking a valid result.
REQ-010 Port sum  output  WIDTH  SHALL carry the result, valid from done and held until the next accepted start.
REQ-011 Port cout  output  1  SHALL carry the final carry-out, with the same validity as sum.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE; busy SHALL be high only in RUN.
REQ-013 In IDLE or DONE, start=1 SHALL load a, b and cin into shift/carry registers, clear the bit counter and move to RUN.
REQ-014 In RUN, each cycle SHALL add the LSBs of A and B plus the carry register through one full-adder cell, then:
- store the carry bit;
- shift the sum bit into the sum register from the MSB side;
- shift A and B right by one.
REQ-015 After the WIDTH-th RUN cycle, the FSM SHALL enter DONE and drive done=1 for exactly that one cycle, with sum and cout final in that cycle.
REQ-016 Latency: start accepted at edge N SHALL give done=1 in the cycle following edge N+WIDTH.
REQ-017 From DONE, the FSM SHALL return to IDLE; start=1 in DONE SHALL be accepted (back-to-back, no idle cycle).
REQ-018 start asserted while in RUN SHALL be ignored, with no effect on operands or timing.
REQ-019 Arithmetic SHALL be unsigned modulo 2^WIDTH on sum, with cout as bit WIDTH of a+b+cin.
REQ-020 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap during a RUN.

Reset
REQ-021 rst=1 SHALL force state IDLE and clear busy, done, sum, cout and all internal registers to 0 at the next edge.
REQ-022 rst SHALL override start and any in-progress RUN; an aborted addition SHALL produce no done pulse.

Configuration
REQ-023 With macro SERIAL_ADDER_OVF_EN defined:
- an extra port ovf (output, 1 bit) SHALL report two's-complement overflow, i.e. the carry into the MSB XOR cout;
- ovf SHALL have the same validity as sum;
- ovf SHALL reset to 0.
REQ-024 Without SERIAL_ADDER_OVF_EN, port ovf and its logic SHALL be absent.

Structure
REQ-025 Package serial_adder_pkg SHALL hold the state enumeration (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-026 The per-bit adder SHALL be a sub-module fa_cell with inputs a, b, cin and outputs sum, carry, built as two half-adder stages plus an OR gate, instantiated exactly once.

Verification
REQ-027 WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, done exactly 9 cycles after the start edge, busy high for 8 cycles.
REQ-028 a=0x3C, b=0x5A, cin=1 -> sum=0x97, cout=0; then start held high in DONE with a=0x01, b=0x01 -> second result sum=0x02 with no idle cycle between the two runs.
REQ-029 start pulsed at RUN cycle 3 with different operands -> ignored, and the first result is unchanged.
REQ-030 rst asserted at RUN cycle 4 -> next cycle all outputs are 0, state is IDLE, and no done pulse follows.
REQ-031 With SERIAL_ADDER_OVF_EN: a=0x7F, b=0x01 -> ovf=1, sum=0x80; a=0xFF, b=0x01 -> ovf=0, cout=1.
REQ-032 Random sweep of 1000 operand/cin triples -> {cout,sum} equals a+b+cin each time.
